// File: rtl/shared_op_arbiter_pkg.sv
// State encoding and operation-name constants shared by the arbiter and its arithmetic unit.
package shared_op_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam string OP_ADD = "add";
    localparam string OP_SUB = "sub";
    localparam string OP_MUL = "mul";

endpackage

// File: rtl/operator.sv
// Combinational reduction of input_size operands with one fixed operation, truncated to data_width.
module operator
    import shared_op_arbiter_pkg::*;
#(
    parameter int    data_width = 32,
    parameter int    input_size = 2,
    parameter string op         = OP_ADD
) (
    input  logic [data_width*input_size-1:0] din,
    output logic [data_width-1:0]            dout
);

    always_comb begin
        dout = din[data_width-1:0];
        for (int i = 1; i < input_size; i++) begin
            if (op == OP_SUB) begin
                dout = dout - din[i*data_width +: data_width];
            end else if (op == OP_MUL) begin
                dout = dout * din[i*data_width +: data_width];
            end else begin
                dout = dout + din[i*data_width +: data_width];
            end
        end
    end

endmodule

// File: rtl/rr_picker.sv
// Round-robin winner search starting one past the last grant, wrapping; purely combinational.
module rr_picker #(
    parameter  int num_ports = 4,
    localparam int IW        = $clog2(num_ports)
) (
    input  logic [num_ports-1:0] elig,
    input  logic [IW-1:0]        last,
    output logic [IW-1:0]        win,
    output logic                 vld
);

    logic [IW-1:0] cand;

    // Walk from farthest to nearest so the nearest eligible port overwrites earlier hits.
    always_comb begin
        win  = '0;
        vld  = 1'b0;
        cand = '0;
        for (int i = num_ports; i >= 1; i--) begin
            cand = IW'((int'(last) + i) % num_ports);
            if (elig[cand]) begin
                win = cand;
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shared_op_arbiter.sv
// Round-robin arbiter sharing one arithmetic unit among num_ports requesters; SHARED_OP_ARBITER_STATS_EN adds counters.
// Latency: grant edge + latency EXEC cycles, then a one-cycle RESP with ack and dout.
// Backpressure: none; requesters hold req until acked, and the acked port is ineligible in its ack cycle.
module shared_op_arbiter
    import shared_op_arbiter_pkg::*;
#(
    parameter int    data_width = 32,
    parameter int    num_ports  = 4,
    parameter string op         = OP_ADD,
    parameter int    latency    = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [num_ports-1:0]            req,
    input  logic [data_width*num_ports-1:0] din_a,
    input  logic [data_width*num_ports-1:0] din_b,
    output logic [num_ports-1:0]            ack,
    output logic [data_width-1:0]           dout,
    output logic [$clog2(num_ports)-1:0]    grant_id,
`ifdef SHARED_OP_ARBITER_STATS_EN
    output logic                            busy,
    output logic [31:0]                     grant_count,
    output logic [31:0]                     busy_count
`else
    output logic                            busy
`endif
);

    localparam int IW = $clog2(num_ports);
    localparam int CW = (latency > 1) ? $clog2(latency) : 1;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [data_width-1:0] a_q, a_d, b_q, b_d, dout_q, dout_d, result;
    logic [IW-1:0]         grant_q, grant_d, last_q, last_d, win;
    logic                  win_vld;
    logic [num_ports-1:0]  ack_vec, eligible;

    // Gated by rst so an operation aborted in RESP never shows its ack.
    always_comb begin
        ack_vec = '0;
        if (state_q == RESP && !rst) begin
            ack_vec[grant_q] = 1'b1;
        end
    end

    assign eligible = req & ~ack_vec;

    rr_picker #(.num_ports(num_ports)) u_picker (
        .elig (eligible),
        .last (last_q),
        .win  (win),
        .vld  (win_vld)
    );

    operator #(.data_width(data_width), .input_size(2), .op(op)) u_operator (
        .din  ({b_q, a_q}),
        .dout (result)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        grant_d = grant_q;
        last_d  = last_q;
        dout_d  = dout_q;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    a_d     = din_a[int'(win)*data_width +: data_width];
                    b_d     = din_b[int'(win)*data_width +: data_width];
                    grant_d = win;
                    cnt_d   = CW'(latency - 1);
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    dout_d  = result;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                last_d  = grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            grant_q <= '0;
            last_q  <= IW'(num_ports - 1);
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            dout_q  <= dout_d;
        end
    end

    assign ack      = ack_vec;
    assign dout     = dout_q;
    assign grant_id = grant_q;
    assign busy     = (state_q != IDLE);

`ifdef SHARED_OP_ARBITER_STATS_EN
    logic [31:0] grant_count_q, grant_count_d, busy_count_q, busy_count_d;

    always_comb begin
        grant_count_d = grant_count_q + 32'(|ack_vec);
        busy_count_d  = busy_count_q + 32'(busy);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_count_q <= '0;
            busy_count_q  <= '0;
        end else begin
            grant_count_q <= grant_count_d;
            busy_count_q  <= busy_count_d;
        end
    end

    assign grant_count = grant_count_q;
    assign busy_count  = busy_count_q;
`endif

endmodule

// File: tb/tb_shared_op_arbiter.sv
// Directed-vector bench: an add/latency-1 instance and a sub/latency-4 instance on one clock and reset.
module tb_shared_op_arbiter;

    localparam int W = 32;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req0, req1, ack0, ack1;
    logic [W*N-1:0] a0, b0, a1, b1;
    logic [W-1:0]   dout0, dout1;
    logic [1:0]     gid0, gid1;
    logic           busy0, busy1;
`ifdef SHARED_OP_ARBITER_STATS_EN
    logic [31:0]    gc0, bc0, gc1, bc1;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    shared_op_arbiter #(.data_width(W), .num_ports(N), .op("add"), .latency(1)) u_dut_add (
        .clk(clk), .rst(rst), .req(req0), .din_a(a0), .din_b(b0),
        .ack(ack0), .dout(dout0), .grant_id(gid0),
`ifdef SHARED_OP_ARBITER_STATS_EN
        .busy(busy0), .grant_count(gc0), .busy_count(bc0)
`else
        .busy(busy0)
`endif
    );

    shared_op_arbiter #(.data_width(W), .num_ports(N), .op("sub"), .latency(4)) u_dut_sub (
        .clk(clk), .rst(rst), .req(req1), .din_a(a1), .din_b(b1),
        .ack(ack1), .dout(dout1), .grant_id(gid1),
`ifdef SHARED_OP_ARBITER_STATS_EN
        .busy(busy1), .grant_count(gc1), .busy_count(bc1)
`else
        .busy(busy1)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One single-port operation on the add instance; ends back in IDLE.
    task automatic do_op0(input int port, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string tag);
        logic [N-1:0] onehot;
        bit found;
        onehot       = '0;
        onehot[port] = 1'b1;
        a0[port*W +: W] = a;
        b0[port*W +: W] = b;
        req0 = onehot;
        tick();
        req0  = '0;
        found = 1'b0;
        for (int n = 0; n < 8 && !found; n++) begin
            tick();
            if (|ack0) found = 1'b1;
        end
        check({tag, "_ack"}, ack0, onehot);
        check({tag, "_dout"}, dout0, exp);
        tick();
        check({tag, "_idle"}, busy0, 1'b0);
    endtask

    // One operation on the sub/latency-4 instance; hold keeps req through the first EXEC cycle.
    task automatic do_op1(input int port, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input bit hold, input string tag);
        logic [N-1:0] onehot;
        int n;
        onehot       = '0;
        onehot[port] = 1'b1;
        a1[port*W +: W] = a;
        b1[port*W +: W] = b;
        req1 = onehot;
        tick();
        n = 1;
        check({tag, "_gid"}, gid1, 64'(port));
        if (hold) begin
            tick();
            n++;
        end
        req1 = '0;
        while (!(|ack1) && n < 12) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, n, 5);
        check({tag, "_ack"}, ack1, onehot);
        check({tag, "_dout"}, dout1, exp);
        tick();
    endtask

    initial begin
        int ack_cyc[5];
        int ack_id[5];
        int n_acks;
        logic [N-1:0] hold_off;

        rst  = 1'b1;
        req0 = '0;
        req1 = '0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        tick();
        tick();
        check("rst_ack0", ack0, 0);
        check("rst_dout0", dout0, 0);
        check("rst_busy0", busy0, 0);
        check("rst_gid0", gid0, 0);
        check("rst_ack1", ack1, 0);
        check("rst_busy1", busy1, 0);

        // Basic add: 5 + 7 on port 0, busy exactly two cycles.
        rst  = 1'b0;
        a0[0 +: W] = 32'd5;
        b0[0 +: W] = 32'd7;
        req0 = 4'b0001;
        tick();
        check("s1_exec_busy", busy0, 1);
        check("s1_exec_ack", ack0, 0);
        check("s1_exec_gid", gid0, 0);
        req0 = '0;
        tick();
        check("s1_resp_ack", ack0, 4'b0001);
        check("s1_resp_dout", dout0, 12);
        check("s1_resp_busy", busy0, 1);
        tick();
        check("s1_after_ack", ack0, 0);
        check("s1_after_busy", busy0, 0);
        check("s1_dout_hold", dout0, 12);
        tick();
        tick();
        check("idle_busy", busy0, 0);
        check("idle_ack", ack0, 0);

        do_op0(1, 32'hFFFF_FFFF, 32'd2, 32'd1, "add_wrap");

        // Round robin with all ports requesting from a fresh reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            a0[i*W +: W] = 32'(i + 1);
            b0[i*W +: W] = 32'(10 * i);
        end
        req0     = 4'hF;
        hold_off = '0;
        n_acks   = 0;
        for (int c = 0; c < 40 && n_acks < 5; c++) begin
            tick();
            req0     = 4'hF & ~hold_off;
            hold_off = '0;
            if (|ack0) begin
                ack_cyc[n_acks] = c;
                for (int b = 0; b < N; b++) if (ack0[b]) ack_id[n_acks] = b;
                check("rr_onehot", $countones(ack0), 1);
                check("rr_dout", dout0, 32'(ack_id[n_acks] + 1 + 10 * ack_id[n_acks]));
                hold_off = ack0;
                n_acks++;
            end
        end
        req0 = '0;
        check("rr_ack_count", n_acks, 5);
        for (int k = 0; k < n_acks; k++) begin
            check("rr_order", ack_id[k], k % N);
            if (k > 0) check("rr_spacing", ack_cyc[k] - ack_cyc[k-1], 3);
        end
        tick();
        tick();

        do_op1(0, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, "sub_neg");
        do_op1(2, 32'd100, 32'd1, 32'd99, 1'b1, "lat4_drop");

        // Abort: last grant is 2, so ports {2,3} pick 3; reset must return priority to port 0.
        req1 = 4'b1100;
        tick();
        check("abort_gid", gid1, 3);
        tick();
        rst = 1'b1;
        check("abort_ack_rst_cycle", ack1, 0);
        tick();
        check("abort_busy", busy1, 0);
        check("abort_gid_cleared", gid1, 0);
        check("abort_ack", ack1, 0);
        rst  = 1'b0;
        req1 = 4'b1101;
        tick();
        check("post_rst_gid", gid1, 0);
        check("post_rst_busy", busy1, 1);
        req1 = '0;
        for (int n = 0; n < 8 && !(|ack1); n++) tick();
        check("post_rst_ack", ack1, 4'b0001);
        tick();

        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            do_op0(0, 32'(i), 32'd1, 32'(i + 1), "stat_op");
        end
`ifdef SHARED_OP_ARBITER_STATS_EN
        check("grant_count", gc0, 10);
        check("busy_count", bc0, 20);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

endmodule
